// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard pins to the 11-bit ps2_key event word.
// Chain: 2-FF synchroniser -> clock glitch filter -> frame receiver -> prefix FSM.
module ps2_key_encoder #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 24000
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic [7:0]    flt_cnt;
   logic          fclk;
   logic          fall;
   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par;
   logic [TW-1:0] timer;
   logic          byte_v;
   logic [7:0]    rx_byte;
   logic          ext;
   logic          brk;
   logic [2:0]    skip;

   // Two-stage synchronisers for both pins; idle level of the bus is high.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
      end
   end

   // Filtered clock follows the synchronised level only after FILTER equal samples; fall marks a high-to-low change.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         flt_cnt <= 8'd0;
         fclk    <= 1'b1;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_sync[1] == fclk) begin
            flt_cnt <= 8'd0;
         end else if (flt_cnt == 8'(FILTER - 1)) begin
            fclk    <= clk_sync[1];
            flt_cnt <= 8'd0;
            fall    <= ~clk_sync[1];
         end else begin
            flt_cnt <= flt_cnt + 8'd1;
         end
      end
   end

   // Frame receiver: start, 8 data bits LSB first, odd parity, stop; inter-edge timeout aborts a frame.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= 3'd0;
         timer   <= '0;
         byte_v  <= 1'b0;
         err     <= 1'b0;
      end else begin
         byte_v <= 1'b0;
         err    <= 1'b0;
         if (state == S_IDLE) begin
            timer <= '0;
            if (fall) begin
               if (!dat_sync[1]) begin
                  state   <= S_DATA;
                  bit_cnt <= 3'd0;
               end else begin
                  err <= 1'b1;
               end
            end
         end else if (fall) begin
            timer <= '0;
            case (state)
               S_DATA: begin
                  shift   <= {dat_sync[1], shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
                  par   <= dat_sync[1];
                  state <= S_STOP;
               end
               S_STOP: begin
                  if (dat_sync[1] && (^{par, shift})) begin
                     byte_v  <= 1'b1;
                     rx_byte <= shift;
                  end else begin
                     err <= 1'b1;
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end else if (timer == TW'(TIMEOUT)) begin
            err   <= 1'b1;
            timer <= '0;
            state <= S_IDLE;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   // Prefix FSM: tracks E0/F0 flags, swallows the Pause sequence and ignores keyboard status bytes.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         ps2_key <= 11'h000;
         ext     <= 1'b0;
         brk     <= 1'b0;
         skip    <= 3'd0;
      end else if (err) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         skip <= 3'd0;
      end else if (byte_v) begin
         if (skip != 3'd0) begin
            skip <= skip - 3'd1;
         end else begin
            case (rx_byte)
               8'hE1: skip <= 3'd7;
               8'hE0: ext  <= 1'b1;
               8'hF0: brk  <= 1'b1;
               8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: begin
               end
               default: begin
                  ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
                  ext     <= 1'b0;
                  brk     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: make/break, errors, timeout, Pause, glitch and reset.
module tb_ps2_key_encoder;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 400;
   localparam int H       = 40;   // half PS/2 clock period in clk_sys cycles

   logic        clk_sys  = 1'b0;
   logic        rst      = 1'b1;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        err;

   int n_cmp   = 0;
   int n_bad   = 0;
   int err_cnt = 0;
   int err_base;

   ps2_key_encoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .err      (err)
   );

   always #5 clk_sys = ~clk_sys;

   // Count every cycle with err high.
   always @(posedge clk_sys) if (err === 1'b1) err_cnt <= err_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk_sys);
      ps2_data = b;
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic bad);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ bad);
      ps2_bit(1'b1);
      repeat (2 * H) @(negedge clk_sys);
   endtask

   initial begin
      // Reset state
      repeat (4) @(negedge clk_sys);
      check("reset_key", 32'(ps2_key), 32'h000);
      check("reset_err", 32'(err), 32'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk_sys);

      // Make 1C with exact latency from the stop-bit falling edge
      err_base = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(((8'h1C >> i) & 8'h01) != 8'h00);
      ps2_bit(1'b0);
      @(negedge clk_sys);
      ps2_data = 1'b1;
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (11) @(posedge clk_sys);
      #1 check("latency_hold", 32'(ps2_key), 32'h000);
      @(posedge clk_sys);
      #1 check("make_1C", 32'(ps2_key), 32'h61C);
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (2 * H) @(negedge clk_sys);
      check("make_no_err", 32'(err_cnt - err_base), 32'd0);

      // Extended break, then plain make of the same code
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      check("ext_break_75", 32'(ps2_key), 32'h175);
      send_byte(8'h75, 1'b0);
      check("make_75", 32'(ps2_key), 32'h675);

      // Parity error
      err_base = err_cnt;
      send_byte(8'h29, 1'b1);
      check("parity_err", 32'(err_cnt - err_base), 32'd1);
      check("parity_key_held", 32'(ps2_key), 32'h675);
      send_byte(8'h29, 1'b0);
      check("make_29", 32'(ps2_key), 32'h229);

      // Timeout after four data bits
      err_base = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TIMEOUT + 10) @(negedge clk_sys);
      check("timeout_err", 32'(err_cnt - err_base), 32'd1);
      check("timeout_key_held", 32'(ps2_key), 32'h229);
      send_byte(8'h05, 1'b0);
      check("make_05", 32'(ps2_key), 32'h605);

      // Pause sequence produces nothing; the next make does
      err_base = err_cnt;
      send_byte(8'hE1, 1'b0);
      send_byte(8'h14, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'hE1, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h14, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h77, 1'b0);
      check("pause_key_held", 32'(ps2_key), 32'h605);
      send_byte(8'h0C, 1'b0);
      check("make_0C", 32'(ps2_key), 32'h20C);
      check("pause_no_err", 32'(err_cnt - err_base), 32'd0);

      // Short glitch on ps2_clk while idle
      err_base = err_cnt;
      @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (50) @(negedge clk_sys);
      check("glitch_no_err", 32'(err_cnt - err_base), 32'd0);
      check("glitch_key_held", 32'(ps2_key), 32'h20C);

      // Reset in the middle of a frame, then a clean frame
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      @(negedge clk_sys);
      rst = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("midreset_key", 32'(ps2_key), 32'h000);
      check("midreset_err", 32'(err), 32'h0);
      rst = 1'b0;
      repeat (2 * H) @(negedge clk_sys);
      err_base = err_cnt;
      send_byte(8'h6B, 1'b0);
      check("make_6B", 32'(ps2_key), 32'h66B);
      check("after_reset_no_err", 32'(err_cnt - err_base), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
